// File: rtl/noc_pkg.sv
// Shared NoC flit types and the 2-to-1 merge FSM state encoding.
package noc_pkg;
    localparam int FLIT_W   = 9;
    localparam int TAIL_BIT = FLIT_W - 1;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} merge_state_e;
endpackage

// File: rtl/out_reg.sv
// Single-entry valid/ready register: loads whenever empty or being drained, so it sustains 1 item/cycle.
module out_reg
    import noc_pkg::*;
#(
    parameter int W = FLIT_W
) (
    input  logic         CLK,
    input  logic         _RESET,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
        end
    end

endmodule

// File: rtl/merge21_arbiter.sv
// Packet-atomic 2-to-1 flit merge with round-robin head arbitration and a 1-bit source token per packet.
module merge21_arbiter
    import noc_pkg::*;
#(
    parameter int W       = FLIT_W,
    parameter bit RR_INIT = 1'b0
) (
    input  logic         CLK,
    input  logic         _RESET,
    input  logic [W-1:0] in0_data,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in1_data,
    input  logic         in1_valid,
    output logic         in1_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         s_data,
    output logic         s_valid,
    input  logic         s_ready
);

    merge_state_e state, state_nx;
    logic         prio, prio_nx;
    logic         flit_can, s_can;
    logic         grant1, sel, acc0, acc1, fire, tail;
    logic [W-1:0] mux_data;

    // Head winner in IDLE: the sole valid input, or the priority holder when both are valid.
    assign grant1   = in1_valid && (!in0_valid || prio);
    assign sel      = (state == LOCK1) || ((state == IDLE) && grant1);
    assign acc0     = in0_valid && in0_ready;
    assign acc1     = in1_valid && in1_ready;
    assign fire     = acc0 || acc1;
    assign mux_data = sel ? in1_data : in0_data;
    assign tail     = mux_data[W-1];

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state <= IDLE;
            prio  <= RR_INIT;
        end else begin
            state <= state_nx;
            prio  <= prio_nx;
        end
    end

    always_comb begin
        state_nx = state;
        prio_nx  = prio;
        case (state)
            IDLE: begin
                if (fire) begin
                    if (tail) prio_nx = !sel;
                    else      state_nx = sel ? LOCK1 : LOCK0;
                end
            end
            LOCK0: begin
                if (acc0 && tail) begin
                    state_nx = IDLE;
                    prio_nx  = 1'b1;
                end
            end
            LOCK1: begin
                if (acc1 && tail) begin
                    state_nx = IDLE;
                    prio_nx  = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A head needs room in both the flit and token registers; body flits only need the flit register.
    always_comb begin
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        if (_RESET) begin
            case (state)
                IDLE: begin
                    in0_ready = flit_can && s_can && in0_valid && !grant1;
                    in1_ready = flit_can && s_can && grant1;
                end
                LOCK0:   in0_ready = flit_can;
                LOCK1:   in1_ready = flit_can;
                default: ;
            endcase
        end
    end

    out_reg #(.W(W)) u_flit_reg (
        .CLK       (CLK),
        ._RESET    (_RESET),
        .in_data   (mux_data),
        .in_valid  (fire),
        .in_ready  (flit_can),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    out_reg #(.W(1)) u_s_reg (
        .CLK       (CLK),
        ._RESET    (_RESET),
        .in_data   (sel),
        .in_valid  (fire && (state == IDLE)),
        .in_ready  (s_can),
        .out_data  (s_data),
        .out_valid (s_valid),
        .out_ready (s_ready)
    );

endmodule

// File: tb/tb_merge21_arbiter.sv
// Directed bench for merge21_arbiter: queue-fed sources, a negedge monitor, and hand-computed expectations.
module tb_merge21_arbiter;
    import noc_pkg::*;

    logic  CLK = 1'b0;
    logic  _RESET;
    flit_t in0_data, in1_data, out_data;
    logic  in0_valid, in0_ready, in1_valid, in1_ready;
    logic  out_valid, out_ready, s_data, s_valid, s_ready;

    merge21_arbiter #(.W(FLIT_W), .RR_INIT(1'b0)) dut (
        .CLK(CLK), ._RESET(_RESET),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready)
    );

    always #5 CLK = ~CLK;

    int    n_chk = 0, n_fail = 0, cyc = 0, n_acc1 = 0;
    logic  acc0 = 1'b0, acc1 = 1'b0, in1r_seen = 1'b0, rnd_en = 1'b0;
    flit_t q0[$], q1[$], oq[$];
    logic  sq[$];
    int    ocyc[$], acyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic flit_t oq_at(input int i);
        return (i < oq.size()) ? oq[i] : 'x;
    endfunction

    function automatic logic sq_at(input int i);
        return (i < sq.size()) ? sq[i] : 1'bx;
    endfunction

    function automatic int ocyc_at(input int i);
        return (i < ocyc.size()) ? ocyc[i] : -1000;
    endfunction

    // Monitor: transfers are judged half a cycle before the edge that completes them.
    initial forever begin
        @(negedge CLK);
        cyc++;
        acc0 = in0_valid && in0_ready;
        acc1 = in1_valid && in1_ready;
        if (acc1) n_acc1++;
        if (acc0 || acc1) acyc.push_back(cyc);
        if (out_valid && out_ready) begin
            oq.push_back(out_data);
            ocyc.push_back(cyc);
        end
        if (s_valid && s_ready) sq.push_back(s_data);
        if (in1_ready) in1r_seen = 1'b1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        if (acc0 && q0.size() > 0) void'(q0.pop_front());
        if (acc1 && q1.size() > 0) void'(q1.pop_front());
        in0_valid = (q0.size() > 0);
        in0_data  = in0_valid ? q0[0] : '0;
        in1_valid = (q1.size() > 0);
        in1_data  = in1_valid ? q1[0] : '0;
        if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic clr_mon();
        oq.delete(); sq.delete(); ocyc.delete(); acyc.delete();
        in1r_seen = 1'b0;
        n_acc1 = 0;
    endtask

    task automatic drain(input string tag, input int budget);
        int  k;
        logic done;
        k = 0;
        done = 1'b0;
        while (!done && k < budget) begin
            tick();
            k++;
            done = (q0.size() == 0) && (q1.size() == 0) && !in0_valid && !in1_valid
                   && !out_valid && !s_valid;
        end
        chk(tag, done, 1'b1);
    endtask

    task automatic do_reset();
        _RESET = 1'b0;
        q0.delete(); q1.delete();
        in0_valid = 1'b0; in1_valid = 1'b0;
        tick(); tick();
        _RESET = 1'b1;
        clr_mon();
    endtask

    initial begin
        flit_t exp_f[$];
        logic  exp_s[$];
        int    c_rel;

        _RESET = 1'b0;
        in0_valid = 1'b1; in0_data = 9'h011;
        in1_valid = 1'b1; in1_data = 9'h180;
        out_ready = 1'b1; s_ready = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_s_valid",   s_valid,   1'b0);
        chk("rst_out_data",  out_data,  9'h000);
        chk("rst_s_data",    s_data,    1'b0);
        chk("rst_in0_ready", in0_ready, 1'b0);
        chk("rst_in1_ready", in1_ready, 1'b0);
        do_reset();

        // 1: three-flit packet from in0
        q0 = '{9'h011, 9'h022, 9'h123};
        drain("t1_drain", 30);
        chk("t1_count", oq.size(), 3);
        chk("t1_f0", oq_at(0), 9'h011);
        chk("t1_f1", oq_at(1), 9'h022);
        chk("t1_f2", oq_at(2), 9'h123);
        chk("t1_s_count", sq.size(), 1);
        chk("t1_s0", sq_at(0), 1'b0);
        chk("t1_in1_ready_low", in1r_seen, 1'b0);
        chk("t1_consecutive", ocyc_at(2) - ocyc_at(0), 2);
        chk("t1_latency", ocyc_at(0) - ((acyc.size() > 0) ? acyc[0] : -1000), 1);

        // 2: both inputs streaming single-flit packets from prio=0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(flit_t'(9'h100 + i));
            q1.push_back(flit_t'(9'h180 + i));
        end
        exp_f.delete(); exp_s.delete();
        for (int i = 0; i < 4; i++) begin
            exp_f.push_back(flit_t'(9'h100 + i)); exp_s.push_back(1'b0);
            exp_f.push_back(flit_t'(9'h180 + i)); exp_s.push_back(1'b1);
        end
        drain("t2_drain", 40);
        chk("t2_count", oq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_f%0d", i), oq_at(i), exp_f[i]);
            chk($sformatf("t2_s%0d", i), sq_at(i), exp_s[i]);
        end
        chk("t2_throughput", ocyc_at(7) - ocyc_at(0), 7);

        // 3: in0 arrives while in1 is mid-packet
        clr_mon();
        q1 = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h1A4};
        tick(); tick();
        q0 = '{9'h0B1, 9'h1B2};
        drain("t3_drain", 40);
        exp_f = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h1A4, 9'h0B1, 9'h1B2};
        chk("t3_count", oq.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t3_f%0d", i), oq_at(i), exp_f[i]);
        chk("t3_s0", sq_at(0), 1'b1);
        chk("t3_s1", sq_at(1), 1'b0);
        chk("t3_next_head", ocyc_at(4) - ocyc_at(3), 1);

        // 4: random out_ready backpressure over three 4-flit packets
        clr_mon();
        void'($urandom(1));
        exp_f.delete();
        for (int p = 0; p < 3; p++)
            for (int f = 0; f < 4; f++)
                exp_f.push_back(flit_t'({(f == 3), 8'(8'h40 + p * 16 + f)}));
        q0 = exp_f;
        rnd_en = 1'b1;
        drain("t4_drain", 300);
        rnd_en = 1'b0;
        out_ready = 1'b1;
        chk("t4_count", oq.size(), 12);
        for (int i = 0; i < 12; i++) chk($sformatf("t4_f%0d", i), oq_at(i), exp_f[i]);
        chk("t4_s_count", sq.size(), 3);

        // 5: token register held full; body flits flow, next head waits
        clr_mon();
        s_ready = 1'b0;
        q0 = '{9'h0C1, 9'h0C2, 9'h1C3};
        tick(); tick();
        q1 = '{9'h1D1};
        repeat (6) tick();
        chk("t5_body_count", oq.size(), 3);
        chk("t5_body_consec", ocyc_at(2) - ocyc_at(0), 2);
        chk("t5_no_token", sq.size(), 0);
        chk("t5_head_held", in1_valid, 1'b1);
        s_ready = 1'b1;
        c_rel = cyc;
        drain("t5_drain", 20);
        chk("t5_head", oq_at(3), 9'h1D1);
        chk("t5_resume", ocyc_at(3), c_rel + 2);
        chk("t5_s0", sq_at(0), 1'b0);
        chk("t5_s1", sq_at(1), 1'b1);

        // 6: reset mid-packet after in0 has left prio=1
        clr_mon();
        q0 = '{9'h1E0};
        drain("t6_pre_drain", 20);
        clr_mon();
        q1 = '{9'h0F1, 9'h0F2, 9'h0F3, 9'h1F4};
        for (int k = 0; k < 20 && n_acc1 < 2; k++) tick();
        chk("t6_two_accepted", n_acc1, 2);
        _RESET = 1'b0;
        #1;
        chk("t6_rst_out_valid", out_valid, 1'b0);
        chk("t6_rst_s_valid",   s_valid,   1'b0);
        chk("t6_rst_in1_ready", in1_ready, 1'b0);
        q0.delete(); q1.delete();
        in0_valid = 1'b0; in1_valid = 1'b0;
        tick(); tick();
        _RESET = 1'b1;
        clr_mon();
        q0 = '{9'h1E1};
        q1 = '{9'h1F5};
        drain("t6_drain", 20);
        chk("t6_count", oq.size(), 2);
        chk("t6_first", oq_at(0), 9'h1E1);
        chk("t6_second", oq_at(1), 9'h1F5);
        chk("t6_s0", sq_at(0), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule
